// File: rtl/i2c_master_byte_ctrl.sv
`default_nettype none
// ============================================================================
// i2c_master_byte_ctrl : byte-level I2C master sequencer feeding i2c_master_phy
// Optional macro NACK_AUTO_STOP_EN (STOP after NACKed write).  Rev 1.0
// ============================================================================
module i2c_master_byte_ctrl (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_start_i,
  input  logic       cmd_write_i,
  input  logic       cmd_read_i,
  input  logic       cmd_stop_i,
  input  logic       cmd_nack_i,
  input  logic [7:0] wr_data_i,
  output logic [7:0] rd_data_o,
  output logic       ack_rcvd_o,
  output logic       done_o,
  output logic       err_o,
  output logic [1:0] err_code_o,
  output logic       bus_owned_o,
  output logic [2:0] phy_cmd_o,
  output logic       phy_data_o,
  input  logic       phy_data_i,
  input  logic       phy_done_i,
  input  logic       phy_arb_lost_i,
  input  logic       phy_sda_err_i,
  input  logic       phy_scl_err_i,
  input  logic       phy_bus_busy_i
);
  localparam logic [2:0] PHY_IDLE  = 3'd0;
  localparam logic [2:0] PHY_START = 3'd1;
  localparam logic [2:0] PHY_WRITE = 3'd2;
  localparam logic [2:0] PHY_READ  = 3'd3;
  localparam logic [2:0] PHY_STOP  = 3'd4;

  localparam logic [2:0] IDLE_S     = 3'd0;
  localparam logic [2:0] WAIT_BUS_S = 3'd1;
  localparam logic [2:0] START_S    = 3'd2;
  localparam logic [2:0] WR_BIT_S   = 3'd3;
  localparam logic [2:0] WR_ACK_S   = 3'd4;
  localparam logic [2:0] RD_BIT_S   = 3'd5;
  localparam logic [2:0] RD_ACK_S   = 3'd6;
  localparam logic [2:0] STOP_S     = 3'd7;

  logic [2:0] state, state_nxt, after_start;
  logic [2:0] cnt, cnt_nxt;
  logic       phy_done_d;
  logic       f_write, f_read, f_stop, f_nack;
  logic [7:0] wr_byte_r, wr_byte;
  logic       accept, step_done, abort, nack_stop;
  logic       use_write, use_read, use_stop;
  logic [2:0] phy_cmd_nxt;
  logic       phy_data_nxt, done_nxt, err_nxt;
  logic [1:0] err_code_nxt;

  assign cmd_ready_o = (state == IDLE_S);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign step_done   = phy_done_i && !phy_done_d;
  assign abort       = (state != IDLE_S) && (phy_arb_lost_i || phy_sda_err_i || phy_scl_err_i);

  // During the accept cycle the flags are not registered yet, so use the inputs.
  assign use_write   = accept ? cmd_write_i : f_write;
  assign use_read    = accept ? (cmd_read_i && !cmd_write_i) : f_read;
  assign use_stop    = accept ? cmd_stop_i : f_stop;
  assign wr_byte     = accept ? wr_data_i : wr_byte_r;
  assign after_start = use_write ? WR_BIT_S : (use_read ? RD_BIT_S : (use_stop ? STOP_S : IDLE_S));
  assign cnt_nxt     = (state == WR_BIT_S || state == RD_BIT_S) ?
                       (step_done ? cnt - 3'd1 : cnt) : 3'd7;

`ifdef NACK_AUTO_STOP_EN
  assign nack_stop = phy_data_i;
`else
  assign nack_stop = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE_S;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE_S;
    end else begin
      case (state)
        IDLE_S:     if (accept) begin
                      if (cmd_start_i)
                        state_nxt = (phy_bus_busy_i && !bus_owned_o) ? WAIT_BUS_S : START_S;
                      else
                        state_nxt = after_start;
                    end
        WAIT_BUS_S: if (!phy_bus_busy_i) state_nxt = START_S;
        START_S:    if (step_done) state_nxt = after_start;
        WR_BIT_S:   if (step_done && cnt == 3'd0) state_nxt = WR_ACK_S;
        WR_ACK_S:   if (step_done) state_nxt = (use_stop || nack_stop) ? STOP_S : IDLE_S;
        RD_BIT_S:   if (step_done && cnt == 3'd0) state_nxt = RD_ACK_S;
        RD_ACK_S:   if (step_done) state_nxt = use_stop ? STOP_S : IDLE_S;
        STOP_S:     if (step_done) state_nxt = IDLE_S;
        default:    state_nxt = IDLE_S;
      endcase
    end
  end

  always_comb begin
    phy_cmd_nxt  = PHY_IDLE;
    phy_data_nxt = 1'b1;
    case (state_nxt)
      START_S:  phy_cmd_nxt = PHY_START;
      WR_BIT_S: begin
        phy_cmd_nxt  = PHY_WRITE;
        phy_data_nxt = wr_byte[cnt_nxt];
      end
      WR_ACK_S, RD_BIT_S: phy_cmd_nxt = PHY_READ;
      RD_ACK_S: begin
        phy_cmd_nxt  = PHY_WRITE;
        phy_data_nxt = f_nack;
      end
      STOP_S:   phy_cmd_nxt = PHY_STOP;
      default:  phy_cmd_nxt = PHY_IDLE;
    endcase
    done_nxt     = (state_nxt == IDLE_S) && (state != IDLE_S || accept);
    err_nxt      = abort;
    err_code_nxt = phy_arb_lost_i ? 2'd1 : (phy_sda_err_i ? 2'd2 : 2'd3);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      phy_done_d  <= 1'b0;
      cnt         <= 3'd7;
      f_write     <= 1'b0;
      f_read      <= 1'b0;
      f_stop      <= 1'b0;
      f_nack      <= 1'b0;
      wr_byte_r   <= 8'h00;
      rd_data_o   <= 8'h00;
      ack_rcvd_o  <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= 2'd0;
      bus_owned_o <= 1'b0;
      phy_cmd_o   <= PHY_IDLE;
      phy_data_o  <= 1'b1;
    end else begin
      phy_done_d <= phy_done_i;
      cnt        <= cnt_nxt;
      phy_cmd_o  <= phy_cmd_nxt;
      phy_data_o <= phy_data_nxt;
      done_o     <= done_nxt;
      err_o      <= err_nxt;
      if (accept) begin
        f_write    <= cmd_write_i;
        f_read     <= cmd_read_i && !cmd_write_i;
        f_stop     <= cmd_stop_i;
        f_nack     <= cmd_nack_i;
        wr_byte_r  <= wr_data_i;
        err_code_o <= 2'd0;
      end
      if (abort) begin
        err_code_o  <= err_code_nxt;
        bus_owned_o <= 1'b0;
      end else if (step_done) begin
        case (state)
          START_S:  bus_owned_o <= 1'b1;
          STOP_S:   bus_owned_o <= 1'b0;
          WR_ACK_S: ack_rcvd_o  <= !phy_data_i;
          RD_BIT_S: rd_data_o   <= {rd_data_o[6:0], phy_data_i};
          default:  ;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_i2c_master_byte_ctrl.sv
`default_nettype none
// ============================================================================
// tb_i2c_master_byte_ctrl : directed self-checking bench for i2c_master_byte_ctrl.  Rev 1.0
// ============================================================================
module tb_i2c_master_byte_ctrl;
  localparam logic [2:0] P_IDLE  = 3'd0;
  localparam logic [2:0] P_START = 3'd1;
  localparam logic [2:0] P_WRITE = 3'd2;
  localparam logic [2:0] P_READ  = 3'd3;
  localparam logic [2:0] P_STOP  = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_start, cmd_write, cmd_read, cmd_stop, cmd_nack;
  logic [7:0] wr_data, rd_data;
  logic       ack_rcvd, done, err, bus_owned;
  logic [1:0] err_code;
  logic [2:0] phy_cmd;
  logic       phy_data_o, phy_data_i, phy_done;
  logic       arb_lost, sda_err, scl_err, bus_busy;

  int errors = 0;
  int checks = 0;
  int done_pulses = 0;
  int pulses_before;

  logic       snap_done, snap_err, snap_ready, snap_ack, snap_owned;
  logic [7:0] snap_rd;

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && done) done_pulses <= done_pulses + 1;

  i2c_master_byte_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_start_i(cmd_start), .cmd_write_i(cmd_write), .cmd_read_i(cmd_read),
    .cmd_stop_i(cmd_stop), .cmd_nack_i(cmd_nack), .wr_data_i(wr_data),
    .rd_data_o(rd_data), .ack_rcvd_o(ack_rcvd), .done_o(done), .err_o(err),
    .err_code_o(err_code), .bus_owned_o(bus_owned),
    .phy_cmd_o(phy_cmd), .phy_data_o(phy_data_o), .phy_data_i(phy_data_i),
    .phy_done_i(phy_done), .phy_arb_lost_i(arb_lost), .phy_sda_err_i(sda_err),
    .phy_scl_err_i(scl_err), .phy_bus_busy_i(bus_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One phy step: verify the issued command, then complete it after `hold` cycles of done.
  task automatic step(input string tag, input logic [2:0] ecmd, input logic edata,
                      input logic rbit, input int hold);
    check({tag, " cmd"}, 32'(phy_cmd), 32'(ecmd));
    if (ecmd == P_WRITE) check({tag, " data"}, 32'(phy_data_o), 32'(edata));
    phy_data_i = rbit;
    phy_done   = 1'b1;
    @(negedge clk);
    snap_done  = done;
    snap_err   = err;
    snap_ready = cmd_ready;
    snap_ack   = ack_rcvd;
    snap_owned = bus_owned;
    snap_rd    = rd_data;
    repeat (hold - 1) @(negedge clk);
    phy_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr_steps(input string tag, input logic [7:0] d, input int hold);
    for (int i = 7; i >= 0; i--) step(tag, P_WRITE, d[i], 1'b1, hold);
  endtask

  task automatic rd_steps(input string tag, input logic [7:0] d);
    for (int i = 7; i >= 0; i--) step(tag, P_READ, 1'b1, d[i], 1);
  endtask

  task automatic issue(input logic s, input logic w, input logic r, input logic p,
                       input logic n, input logic [7:0] d);
    check("ready before accept", 32'(cmd_ready), 32'd1);
    cmd_start = s; cmd_write = w; cmd_read = r; cmd_stop = p; cmd_nack = n; wr_data = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_start = 1'b0; cmd_write = 1'b0; cmd_read = 1'b0;
    cmd_stop = 1'b0; cmd_nack = 1'b0; wr_data = 8'h00; phy_data_i = 1'b1; phy_done = 1'b0;
    arb_lost = 1'b0; sda_err = 1'b0; scl_err = 1'b0; bus_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst ready", 32'(cmd_ready), 32'd1);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst err_code", 32'(err_code), 32'd0);
    check("rst rd_data", 32'(rd_data), 32'd0);
    check("rst ack", 32'(ack_rcvd), 32'd0);
    check("rst owned", 32'(bus_owned), 32'd0);
    check("rst phy_cmd", 32'(phy_cmd), 32'(P_IDLE));
    check("rst phy_data", 32'(phy_data_o), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty command finishes one cycle after accept
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("empty done", 32'(done), 32'd1);
    check("empty ready", 32'(cmd_ready), 32'd1);
    check("empty phy_cmd", 32'(phy_cmd), 32'(P_IDLE));
    @(negedge clk);
    check("empty done pulse", 32'(done), 32'd0);

    // Error inputs while idle are ignored
    arb_lost = 1'b1;
    @(negedge clk);
    arb_lost = 1'b0;
    check("idle err ignored", 32'(err), 32'd0);
    check("idle code ignored", 32'(err_code), 32'd0);

    // start + write 0xA4 + stop, slave ACKs
    issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA4);
    check("A busy", 32'(cmd_ready), 32'd0);
    step("A start", P_START, 1'b1, 1'b1, 1);
    check("A owned after start", 32'(snap_owned), 32'd1);
    wr_steps("A wr", 8'hA4, 1);
    step("A ack", P_READ, 1'b1, 1'b0, 1);
    check("A no done before stop", 32'(snap_done), 32'd0);
    step("A stop", P_STOP, 1'b1, 1'b1, 1);
    check("A done", 32'(snap_done), 32'd1);
    check("A ready", 32'(snap_ready), 32'd1);
    check("A ack_rcvd", 32'(snap_ack), 32'd1);
    check("A owned", 32'(snap_owned), 32'd0);
    check("A err", 32'(snap_err), 32'd0);
    check("A idle after", 32'(phy_cmd), 32'(P_IDLE));

    // start + read (NACK) + stop, slave returns 0x5C
    issue(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    step("B start", P_START, 1'b1, 1'b1, 1);
    rd_steps("B rd", 8'h5C);
    step("B nack", P_WRITE, 1'b1, 1'b1, 1);
    step("B stop", P_STOP, 1'b1, 1'b1, 1);
    check("B done", 32'(snap_done), 32'd1);
    check("B rd_data", 32'(snap_rd), 32'h5C);

    // Long phy_done levels: each step counted once, one completion
    pulses_before = done_pulses;
    issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
    step("C start", P_START, 1'b1, 1'b1, 40);
    wr_steps("C wr", 8'h3C, 40);
    step("C ack", P_READ, 1'b1, 1'b0, 40);
    check("C done", 32'(snap_done), 32'd1);
    check("C ack_rcvd", 32'(snap_ack), 32'd1);
    check("C owned", 32'(snap_owned), 32'd1);
    repeat (5) @(negedge clk);
    check("C idle after", 32'(phy_cmd), 32'(P_IDLE));
    check("C done count", 32'(done_pulses - pulses_before), 32'd1);

    // Repeated start while owned ignores bus busy
    bus_busy = 1'b1;
    issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step("D start", P_START, 1'b1, 1'b1, 1);
    step("D stop", P_STOP, 1'b1, 1'b1, 1);
    check("D owned", 32'(snap_owned), 32'd0);

    // Start while busy and not owned waits for the bus
    issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check("E waiting cmd", 32'(phy_cmd), 32'(P_IDLE));
      @(negedge clk);
    end
    check("E waiting ready", 32'(cmd_ready), 32'd0);
    bus_busy = 1'b0;
    @(negedge clk);
    step("E start", P_START, 1'b1, 1'b1, 1);
    step("E stop", P_STOP, 1'b1, 1'b1, 1);
    check("E done", 32'(snap_done), 32'd1);

    // Arbitration lost during WR_BIT with cnt=3
    issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA4);
    step("F start", P_START, 1'b1, 1'b1, 1);
    for (int i = 7; i >= 4; i--) step("F wr", P_WRITE, (i == 7 || i == 5), 1'b1, 1);
    check("F cnt3 cmd", 32'(phy_cmd), 32'(P_WRITE));
    arb_lost = 1'b1;
    @(negedge clk);
    arb_lost = 1'b0;
    check("F abort cmd", 32'(phy_cmd), 32'(P_IDLE));
    check("F abort done", 32'(done), 32'd1);
    check("F abort err", 32'(err), 32'd1);
    check("F abort code", 32'(err_code), 32'd1);
    check("F abort ready", 32'(cmd_ready), 32'd1);
    check("F abort owned", 32'(bus_owned), 32'd0);
    @(negedge clk);
    check("F err pulse", 32'(err), 32'd0);
    check("F code held", 32'(err_code), 32'd1);

    // Abort wins over a simultaneous done edge; sda beats scl
    issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
    check("G code cleared", 32'(err_code), 32'd0);
    check("G start cmd", 32'(phy_cmd), 32'(P_START));
    phy_done = 1'b1; sda_err = 1'b1; scl_err = 1'b1;
    @(negedge clk);
    phy_done = 1'b0; sda_err = 1'b0; scl_err = 1'b0;
    check("G code", 32'(err_code), 32'd2);
    check("G err", 32'(err), 32'd1);
    check("G done", 32'(done), 32'd1);
    check("G owned", 32'(bus_owned), 32'd0);
    check("G cmd", 32'(phy_cmd), 32'(P_IDLE));
    @(negedge clk);

    // Write NACKed without stop request
    issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12);
    step("H start", P_START, 1'b1, 1'b1, 1);
    wr_steps("H wr", 8'h12, 1);
    step("H ack", P_READ, 1'b1, 1'b1, 1);
`ifdef NACK_AUTO_STOP_EN
    check("H no done yet", 32'(snap_done), 32'd0);
    step("H auto stop", P_STOP, 1'b1, 1'b1, 1);
    check("H done", 32'(snap_done), 32'd1);
    check("H ack_rcvd", 32'(snap_ack), 32'd0);
    check("H owned", 32'(snap_owned), 32'd0);
`else
    check("H done", 32'(snap_done), 32'd1);
    check("H ack_rcvd", 32'(snap_ack), 32'd0);
    check("H owned", 32'(snap_owned), 32'd1);
    check("H no stop", 32'(phy_cmd), 32'(P_IDLE));
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step("H stop", P_STOP, 1'b1, 1'b1, 1);
    check("H owned after stop", 32'(snap_owned), 32'd0);
`endif

    // Reset in the middle of a write: no STOP, everything back to reset values
    issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
    step("J start", P_START, 1'b1, 1'b1, 1);
    step("J wr", P_WRITE, 1'b1, 1'b1, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("J cmd", 32'(phy_cmd), 32'(P_IDLE));
    check("J owned", 32'(bus_owned), 32'd0);
    check("J ready", 32'(cmd_ready), 32'd1);
    check("J phy_data", 32'(phy_data_o), 32'd1);
    check("J rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("J no stop", 32'(phy_cmd), 32'(P_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
